// File: rtl/serial_alu_ctrl_pkg.sv
// serial_alu_ctrl_pkg: op codes, FSM states and op legality helper for the serial ALU
package serial_alu_ctrl_pkg;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;
   typedef enum logic [1:0] {IDLE, RUN, SLTFIX, DONE} state_t;
   function automatic logic is_illegal(input logic [2:0] op);
      return op == 3'b011 || op == 3'b100 || op == 3'b101;
   endfunction
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: one-bit four-input multiplexer
module mux_4x1 (
   input  logic       d0,
   input  logic       d1,
   input  logic       d2,
   input  logic       d3,
   input  logic [1:0] sel,
   output logic       y
);
   assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/serial_alu_bit.sv
// serial_alu_bit: combinational 1-bit ALU slice built from and/or/not plus mux_4x1
module serial_alu_bit (
   input  logic       a,
   input  logic       b,
   input  logic       binv,
   input  logic       c_in,
   input  logic       less,
   input  logic [1:0] sel,
   output logic       r,
   output logic       c_out,
   output logic       set
);
   logic b_eff, ab_x, sum, ovf;
   assign b_eff = (b & ~binv) | (~b & binv);
   assign ab_x  = (a & ~b_eff) | (~a & b_eff);
   assign sum   = (ab_x & ~c_in) | (~ab_x & c_in);
   assign c_out = (a & b_eff) | (a & c_in) | (b_eff & c_in);
   assign ovf   = (c_in & ~c_out) | (~c_in & c_out);
   // sign corrected for overflow, so SLT is right even when a-b wraps
   assign set   = (sum & ~ovf) | (~sum & ovf);
   mux_4x1 u_mux (.d0(a & b_eff), .d1(a | b_eff), .d2(sum), .d3(less), .sel(sel), .y(r));
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU, one slice sequenced LSB first with a registered carry
module serial_alu_ctrl
   import serial_alu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);
   state_t           state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             carry, slt_set, r_bit, c_out, set_bit;
   logic [WIDTH-1:0] shifted;
   serial_alu_bit u_bit (
      .a(a_q[cnt]), .b(b_q[cnt]), .binv(op_q[2]), .c_in(carry), .less(1'b0),
      .sel(op_q[1:0]), .r(r_bit), .c_out(c_out), .set(set_bit)
   );
   assign shifted = {r_bit, result[WIDTH-1:1]};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         a_q <= '0;
         b_q <= '0;
         op_q <= '0;
         cnt <= '0;
         carry <= 1'b0;
         slt_set <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         result <= '0;
         carry_out <= 1'b0;
         overflow <= 1'b0;
         zero <= 1'b0;
         illegal <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               a_q <= a;
               b_q <= b;
               op_q <= op;
               cnt <= '0;
               carry <= op[2];
               result <= '0;
               carry_out <= 1'b0;
               overflow <= 1'b0;
               busy <= 1'b1;
               illegal <= is_illegal(op);
               if (is_illegal(op)) begin
                  zero <= 1'b1;
                  done <= 1'b1;
                  state <= DONE;
               end else state <= RUN;
            end
            RUN: begin
               result <= shifted;
               carry <= c_out;
               if (cnt == CNT_W'(WIDTH-1)) begin
                  slt_set <= set_bit;
                  if (op_q[1:0] == 2'b10) begin
                     overflow <= carry ^ c_out;
                     carry_out <= c_out;
                  end
                  if (op_q == OP_SLT) state <= SLTFIX;
                  else begin
                     zero <= shifted == '0;
                     done <= 1'b1;
                     state <= DONE;
                  end
               end else cnt <= cnt + CNT_W'(1);
            end
            SLTFIX: begin
               result <= {{(WIDTH-1){1'b0}}, slt_set};
               zero <= ~slt_set;
               done <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed vectors with hand-computed results for the 8-bit serial ALU
module tb_serial_alu_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [2:0] op = '0;
   logic [7:0] a = '0, b = '0, result;
   logic       busy, done, carry_out, overflow, zero, illegal;
   int         total = 0, bad = 0;

   serial_alu_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out),
      .overflow(overflow), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // wait for done; returns the cycle it appeared in (0 on timeout) and whether busy held throughout
   task automatic wait_done(output int lat, output logic busy_ok);
      lat = 0;
      busy_ok = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         start = 1'b0;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input int exp_lat, input logic [7:0] exp_res, input logic exp_co,
                      input logic exp_ov, input logic exp_z, input logic exp_ill);
      int   lat;
      logic busy_ok;
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      wait_done(lat, busy_ok);
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".busy"}, busy_ok, 1'b1);
      check({tag, ".res"}, result, exp_res);
      check({tag, ".co"}, carry_out, exp_co);
      check({tag, ".ov"}, overflow, exp_ov);
      check({tag, ".zero"}, zero, exp_z);
      check({tag, ".ill"}, illegal, exp_ill);
      tick();
      check({tag, ".post_busy"}, busy, 1'b0);
      check({tag, ".post_done"}, done, 1'b0);
   endtask

   initial begin
      int   lat, extra;
      logic busy_ok;
      tick();
      tick();
      check("rst.busy", busy, 1'b0);
      check("rst.done", done, 1'b0);
      check("rst.res", result, 8'h00);
      check("rst.flags", {carry_out, overflow, zero, illegal}, 4'b0000);
      rst_n = 1'b1;
      tick();

      run("add_ovf", 3'b010, 8'h7F, 8'h01, 9, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      run("sub_eq", 3'b110, 8'h05, 8'h05, 9, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run("slt_lt", 3'b111, 8'h80, 8'h7F, 10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      run("slt_gt", 3'b111, 8'h7F, 8'h80, 10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      run("slt_eq", 3'b111, 8'h03, 8'h03, 10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      run("and", 3'b000, 8'hF0, 8'h3C, 9, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      run("or", 3'b001, 8'hF0, 8'h3C, 9, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0);
      run("illegal", 3'b100, 8'h12, 8'h34, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      run("add_carry", 3'b010, 8'hFF, 8'h01, 9, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      run("sub_neg", 3'b110, 8'h03, 8'h05, 9, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

      // start re-pulsed at cycle 4 with new operands must be ignored, not queued
      op = 3'b010;
      a = 8'h10;
      b = 8'h20;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      a = 8'hFF;
      b = 8'hFF;
      op = 3'b000;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int c = 6; c <= 20; c++) begin
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      check("repulse.lat", lat, 9);
      check("repulse.res", result, 8'h30);
      extra = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done) extra++;
      end
      check("repulse.no_queue", extra, 0);

      // reset mid-operation aborts with no done
      op = 3'b010;
      a = 8'h7F;
      b = 8'h7F;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      check("abort.busy", busy, 1'b0);
      check("abort.res", result, 8'h00);
      rst_n = 1'b1;
      extra = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (done || busy) extra++;
      end
      check("abort.no_done", extra, 0);
      run("add_after", 3'b010, 8'h02, 8'h03, 9, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial ALU engine: one 1-bit ALU slice is sequenced over WIDTH cycles, LSB first, with the carry registered between bits.
- Supports the team's ALU op encoding: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- Used where area matters more than latency; it is the small-footprint alternative to the ripple W-bit ALU and is driven by a simple start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 2.
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  ALU op code (encoding above)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse; result fields valid
- result  out  WIDTH  result; held from done until the next accepted start
- carry_out  out  1  final MSB carry for ADD/SUB, else 0
- overflow  out  1  signed overflow for ADD/SUB (MSB c_in XOR c_out), else 0
- zero  out  1  result == 0, valid with result
- illegal  out  1  op was 011/100/101; valid with result

Behaviour:
- Reset: synchronous active-low; clk and rst_n are the sole clock/reset.
  - All outputs, the shift register, counter and carry go to 0; FSM goes to IDLE.
  - Reset mid-operation aborts the operation; no done is issued.
- FSM states: IDLE, RUN, SLTFIX, DONE.
- IDLE, start=1:
  - Latch a, b, op.
  - cnt <= 0; carry <= op[2], so SUB/SLT start with carry-in 1.
  - Clear result, carry_out, overflow, illegal.
  - Go to RUN, or to DONE with illegal=1 and result=0 if op is illegal.
- RUN: each cycle processes bit cnt.
  - b_eff = b[cnt] XOR op[2].
  - The slice produces and_bit, or_bit, sum_bit and c_out.
  - op[1:0] selects the bit: 00 AND, 01 OR, 10 sum, 11 less; the less input is 0 for every bit.
  - Selected bit is shifted into result from the MSB side (shift right); carry <= c_out.
- At cnt == WIDTH-1 (MSB cycle):
  - set = sum_bit XOR (c_in XOR c_out); this is the overflow-corrected sign.
  - For ADD/SUB: overflow = c_in XOR c_out; carry_out = c_out.
  - SLT goes to SLTFIX; all other ops go to DONE.
- SLTFIX: result <= {WIDTH-1 zeros, set}; go to DONE.
- DONE:
  - done=1 and busy=1 for this one cycle; zero = (result == 0).
  - Next state is IDLE unconditionally; start is not accepted in DONE.
- Latency from the start-sampling edge to the done cycle:
  - AND/OR/ADD/SUB: WIDTH+1 cycles.
  - SLT: WIDTH+2 cycles.
  - Illegal op: 1 cycle.
- Throughput: a new start is accepted the cycle after done at the earliest.
- start while busy is ignored and not queued; operand changes while busy have no effect.
- Carry wrap: the final carry does not feed the next operation; carry is re-initialised at each start.
- Counter stops at WIDTH-1 and never wraps in RUN.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/header: op code constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and FSM state encodings (2-bit).
- Sub-module serial_alu_bit: combinational 1-bit slice.
  - Inputs: a, b, binv, c_in, less, sel[1:0].
  - Outputs: r, c_out, set.
  - Built from and/or/not primitives plus the existing mux_4x1.
- The controller (FSM, counter, shift register, flags) is behavioural RTL.

Test Plan (WIDTH=8, start pulsed at cycle 0):
- ADD a=0x7F b=0x01 -> done at cycle 9; result=0x80, overflow=1, carry_out=0, zero=0, busy high cycles 1-9.
- SUB a=0x05 b=0x05 -> done at cycle 9; result=0x00, zero=1, carry_out=1, overflow=0.
- SLT a=0x80 b=0x7F -> done at cycle 10; result=0x01. Then SLT a=0x7F b=0x80 -> result=0x00. Then SLT a=0x03 b=0x03 -> result=0x00.
- AND a=0xF0 b=0x3C -> result=0x30; OR same operands -> result=0xFC; overflow=0, carry_out=0 for both.
- Illegal op=100 -> done at cycle 1, illegal=1, result=0x00, zero=1.
- ADD started, start re-pulsed at cycle 4 with new operands -> ignored, original result delivered at cycle 9. Separately, rst_n=0 at cycle 5 -> busy=0 and result=0 next edge, no done; a fresh ADD 0x02+0x03 afterwards -> 0x05.
